// File: rtl/tcp_vlg_tx_arb.sv
// Arbitrates tcp_vlg_tx between control segments (tcp_server) and data segments
// (tcp_vlg_tx_queue): latches the winner's header, issues tx_req, reports done/timeout.
module tcp_vlg_tx_arb #(
  parameter int CTL_BURST  = 4,
  parameter int TX_TIMEOUT = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctl_req,
  input  logic        dat_req,
  input  logic [31:0] ctl_seq,
  input  logic [31:0] ctl_ack,
  input  logic [31:0] dat_seq,
  input  logic [31:0] dat_ack,
  input  logic [8:0]  ctl_flags,
  input  logic [8:0]  dat_flags,
  input  logic [15:0] ctl_len,
  input  logic [15:0] dat_len,
  input  logic [31:0] ctl_cs,
  input  logic [31:0] dat_cs,
  output logic        ctl_done,
  output logic        dat_done,
  output logic        ctl_err,
  output logic        dat_err,
  output logic        tx_req,
  output logic [31:0] tx_seq,
  output logic [31:0] tx_ack,
  output logic [8:0]  tx_flags,
  output logic [15:0] tx_len,
  output logic [31:0] tx_cs,
  output logic        tx_sel,
  input  logic        tx_busy,
  input  logic        tx_done
);

  localparam int BURST_W = (CTL_BURST < 1) ? 1 : $clog2(CTL_BURST + 1);
  localparam int TIMER_W = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CTL_BURST);
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'((TX_TIMEOUT < 1) ? 0 : TX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BURST_W-1:0]   r_burst;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_tx_req;
  logic                 r_tx_sel;
  logic [31:0]          r_tx_seq;
  logic [31:0]          r_tx_ack;
  logic [8:0]           r_tx_flags;
  logic [15:0]          r_tx_len;
  logic [31:0]          r_tx_cs;
  logic                 r_ctl_done;
  logic                 r_dat_done;
  logic                 r_ctl_err;
  logic                 r_dat_err;

  logic                 w_grant;
  logic                 w_dat_win;
  logic                 w_done_evt;
  logic                 w_tmo_evt;
  logic                 w_unused;

  // Control length/checksum are defined as zero and tx_busy is status only.
  assign w_unused = ^{tx_busy, ctl_len, ctl_cs};

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_dat_win   = 1'b0;
    w_done_evt  = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dat_win = dat_req && (!ctl_req || (r_burst == BURST_MAX));
        if (ctl_req || dat_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the expiry cycle still counts as done.
        if (tx_done) begin
          w_done_evt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_timer >= TMO_LAST) begin
          w_tmo_evt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Consecutive control grants made while data waits; data wins once saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst <= '0;
    end else if (w_grant) begin
      if (w_dat_win || !dat_req) begin
        r_burst <= '0;
      end else if (r_burst != BURST_MAX) begin
        r_burst <= r_burst + BURST_W'(1);
      end
    end else if ((r_state == S_IDLE) && !dat_req) begin
      r_burst <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state == S_IDLE) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_req   <= 1'b0;
      r_tx_sel   <= 1'b0;
      r_tx_seq   <= '0;
      r_tx_ack   <= '0;
      r_tx_flags <= '0;
      r_tx_len   <= '0;
      r_tx_cs    <= '0;
    end else begin
      r_tx_req <= w_grant;
      if (w_grant) begin
        r_tx_sel <= w_dat_win;
        if (w_dat_win) begin
          r_tx_seq   <= dat_seq;
          r_tx_ack   <= dat_ack;
          r_tx_flags <= dat_flags;
          r_tx_len   <= dat_len;
          r_tx_cs    <= dat_cs;
        end else begin
          r_tx_seq   <= ctl_seq;
          r_tx_ack   <= ctl_ack;
          r_tx_flags <= ctl_flags;
          r_tx_len   <= '0;
          r_tx_cs    <= '0;
        end
      end
    end
  end

  // Completion pulses go to whichever requester owns the latched header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl_done <= 1'b0;
      r_dat_done <= 1'b0;
      r_ctl_err  <= 1'b0;
      r_dat_err  <= 1'b0;
    end else begin
      r_ctl_done <= w_done_evt && !r_tx_sel;
      r_dat_done <= w_done_evt &&  r_tx_sel;
      r_ctl_err  <= w_tmo_evt  && !r_tx_sel;
      r_dat_err  <= w_tmo_evt  &&  r_tx_sel;
    end
  end

  assign tx_req   = r_tx_req;
  assign tx_sel   = r_tx_sel;
  assign tx_seq   = r_tx_seq;
  assign tx_ack   = r_tx_ack;
  assign tx_flags = r_tx_flags;
  assign tx_len   = r_tx_len;
  assign tx_cs    = r_tx_cs;
  assign ctl_done = r_ctl_done;
  assign dat_done = r_dat_done;
  assign ctl_err  = r_ctl_err;
  assign dat_err  = r_dat_err;

endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// Bench for tcp_vlg_tx_arb: arbitration table, corner-case sequences and randomized
// transactions checked against a transaction-level reference model.
module tb_tcp_vlg_tx_arb;

  localparam int P_BURST = 4;
  localparam int P_TMO   = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctl_req = 1'b0, dat_req = 1'b0;
  logic [31:0] ctl_seq = '0, ctl_ack = '0, dat_seq = '0, dat_ack = '0;
  logic [8:0]  ctl_flags = '0, dat_flags = '0;
  logic [15:0] ctl_len = '0, dat_len = '0;
  logic [31:0] ctl_cs = '0, dat_cs = '0;
  logic        ctl_done, dat_done, ctl_err, dat_err;
  logic        tx_req;
  logic [31:0] tx_seq, tx_ack;
  logic [8:0]  tx_flags;
  logic [15:0] tx_len;
  logic [31:0] tx_cs;
  logic        tx_sel;
  logic        tx_busy = 1'b0, tx_done = 1'b0;

  tcp_vlg_tx_arb #(.CTL_BURST(P_BURST), .TX_TIMEOUT(P_TMO)) dut (
    .clk(clk), .rst(rst),
    .ctl_req(ctl_req), .dat_req(dat_req),
    .ctl_seq(ctl_seq), .ctl_ack(ctl_ack), .dat_seq(dat_seq), .dat_ack(dat_ack),
    .ctl_flags(ctl_flags), .dat_flags(dat_flags),
    .ctl_len(ctl_len), .dat_len(dat_len), .ctl_cs(ctl_cs), .dat_cs(dat_cs),
    .ctl_done(ctl_done), .dat_done(dat_done), .ctl_err(ctl_err), .dat_err(dat_err),
    .tx_req(tx_req), .tx_seq(tx_seq), .tx_ack(tx_ack), .tx_flags(tx_flags),
    .tx_len(tx_len), .tx_cs(tx_cs), .tx_sel(tx_sel),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_burst = 0;

  typedef struct {
    logic       c;
    logic       d;
    int         k;
    logic       exp_sel;
    logic [3:0] exp_pls;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [121:0] dut_hdr();
    return {tx_seq, tx_ack, tx_flags, tx_len, tx_cs, tx_sel};
  endfunction

  function automatic logic [3:0] dut_pls();
    return {ctl_done, dat_done, ctl_err, dat_err};
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({tx_req, dut_hdr(), dut_pls()});
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tx_busy = 1'($urandom);
  endtask

  task automatic rand_hdr();
    ctl_seq = $urandom; ctl_ack = $urandom; ctl_flags = 9'($urandom);
    ctl_len = 16'($urandom); ctl_cs = $urandom;
    dat_seq = $urandom; dat_ack = $urandom; dat_flags = 9'($urandom);
    dat_len = 16'($urandom); dat_cs = $urandom;
  endtask

  // Both requests low for n IDLE cycles; a stray tx_done there must be ignored.
  task automatic idle_gap(input int n, input logic junk);
    ctl_req = 1'b0;
    dat_req = 1'b0;
    tx_done = junk;
    for (int t = 0; t < n; t++) begin
      tick();
      tx_done = 1'b0;
      chk("idle_quiet", 128'({tx_req, dut_pls()}), 128'(0));
    end
    m_burst = 0;
  endtask

  // One transfer starting from an IDLE cycle. k = cycles from tx_req to tx_done,
  // k = 0 means tx_done never comes (timeout). Ends on the completion cycle.
  task automatic do_txn(input logic c, input logic d, input int k, input logic junk,
                        input logic scramble, input logic keep_hdr,
                        output logic got_sel, output logic [3:0] got_pls);
    logic         exp_sel;
    logic [121:0] e_hdr;
    logic [3:0]   e_pls;
    int           limit;
    if (!keep_hdr) rand_hdr();
    ctl_req = c;
    dat_req = d;
    exp_sel = d && (!c || (m_burst == P_BURST));
    if (exp_sel || !d) m_burst = 0;
    else if (m_burst < P_BURST) m_burst = m_burst + 1;
    e_hdr = exp_sel ? {dat_seq, dat_ack, dat_flags, dat_len, dat_cs, 1'b1}
                    : {ctl_seq, ctl_ack, ctl_flags, 16'h0, 32'h0, 1'b0};
    if (k == 0) e_pls = exp_sel ? 4'b0001 : 4'b0010;
    else        e_pls = exp_sel ? 4'b0100 : 4'b1000;
    limit = (k == 0) ? P_TMO - 1 : k;
    tick();
    chk("tx_req_rise", 128'(tx_req), 128'(1'b1));
    chk("hdr_latch", 128'(dut_hdr()), 128'(e_hdr));
    chk("pulse_quiet_send", 128'(dut_pls()), 128'(0));
    got_sel = tx_sel;
    tx_done = junk;
    if (scramble) begin
      ctl_req = 1'b0;
      dat_req = 1'b0;
      rand_hdr();
    end
    for (int t = 1; t <= limit; t++) begin
      tick();
      tx_done = 1'b0;
      if (t == 1) chk("tx_req_single", 128'(tx_req), 128'(0));
      if (t == limit) begin
        chk("pulse_before_end", 128'(dut_pls()), 128'(0));
        chk("hdr_hold", 128'(dut_hdr()), 128'(e_hdr));
        tx_done = (k != 0);
      end
    end
    tick();
    got_pls = dut_pls();
    chk("completion", 128'(got_pls), 128'(e_pls));
    tx_done = 1'b0;
    ctl_req = 1'b0;
    dat_req = 1'b0;
  endtask

  initial begin
    logic       gs;
    logic [3:0] gp;
    logic [1:0] cd;
    int         r;
    int         k;

    tbl[0]  = '{1'b1, 1'b1, 5, 1'b0, 4'b1000};
    tbl[1]  = '{1'b1, 1'b1, 5, 1'b0, 4'b1000};
    tbl[2]  = '{1'b1, 1'b1, 5, 1'b0, 4'b1000};
    tbl[3]  = '{1'b1, 1'b1, 5, 1'b0, 4'b1000};
    tbl[4]  = '{1'b1, 1'b1, 5, 1'b1, 4'b0100};
    tbl[5]  = '{1'b1, 1'b1, 5, 1'b0, 4'b1000};
    tbl[6]  = '{1'b1, 1'b0, 1, 1'b0, 4'b1000};
    tbl[7]  = '{1'b0, 1'b1, 1, 1'b1, 4'b0100};
    tbl[8]  = '{1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[9]  = '{1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[10] = '{1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[11] = '{1'b1, 1'b1, 3, 1'b0, 4'b1000};
    tbl[12] = '{1'b1, 1'b1, 0, 1'b1, 4'b0001};
    tbl[13] = '{1'b1, 1'b1, 2, 1'b0, 4'b1000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", all_outs(), 128'(0));
    rst = 1'b0;
    tick();
    chk("post_reset_idle", all_outs(), 128'(0));

    // Lone control request, completion 10 cycles after tx_req
    ctl_seq = 32'h100; ctl_ack = 32'h2345; ctl_flags = 9'h010;
    ctl_len = 16'd77; ctl_cs = 32'hDEAD_BEEF;
    do_txn(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b1, gs, gp);
    chk("ctl_alone_sel", 128'(gs), 128'(1'b0));
    tick();
    chk("ctl_done_single", 128'(dut_pls()), 128'(0));

    // Arbitration table
    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i].c, tbl[i].d, tbl[i].k, 1'(i % 3 == 0), 1'b0, 1'b0, gs, gp);
      chk($sformatf("tbl%0d_sel", i), 128'(gs), 128'(tbl[i].exp_sel));
      chk($sformatf("tbl%0d_pls", i), 128'(gp), 128'(tbl[i].exp_pls));
    end

    // Data inputs change and dat_req drops during WAIT
    do_txn(1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, gs, gp);
    chk("drop_req_done", 128'(gp), 128'(4'b0100));

    // Data timeout with tx_done never arriving
    dat_len = 16'd1400; dat_cs = 32'hABCD1234; dat_seq = 32'h5000; dat_ack = 32'h77;
    dat_flags = 9'h018;
    do_txn(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, gs, gp);
    chk("timeout_err", 128'(gp), 128'(4'b0001));
    tick();
    chk("timeout_quiet", all_outs() & 128'hF, 128'(0));

    // tx_done on the expiry cycle resolves as done
    do_txn(1'b0, 1'b1, P_TMO - 1, 1'b0, 1'b0, 1'b0, gs, gp);
    chk("coincident_done", 128'(gp), 128'(4'b0100));

    // Reset three cycles into WAIT
    rand_hdr();
    ctl_req = 1'b1;
    tick();
    chk("rst_seq_req", 128'(tx_req), 128'(1'b1));
    ctl_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_abort", all_outs(), 128'(0));
    tick();
    chk("rst_hold", all_outs(), 128'(0));
    rst = 1'b0;
    m_burst = 0;
    tick();
    chk("post_rst_quiet", all_outs() & {1'b1, 122'h0, 4'hF}, 128'(0));
    do_txn(1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, gs, gp);
    chk("post_rst_grant", 128'(gs), 128'(1'b0));

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) idle_gap($urandom_range(1, 3), 1'($urandom));
      r  = $urandom_range(3);
      cd = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11;
      r  = $urandom_range(7);
      k  = (r == 0) ? 0 : (r == 1) ? P_TMO - 1 : $urandom_range(1, 12);
      do_txn(cd[1], cd[0], k, 1'($urandom), 1'($urandom), 1'b0, gs, gp);
    end
    tick();
    chk("final_quiet", 128'(dut_pls()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_tx_arb.md
TCP_VLG_TX_ARB -- requirements
Module: tcp_vlg_tx_arb

Interface
REQ-001 SHALL have parameter CTL_BURST, default 4: max consecutive control grants while a data request is pending.
REQ-002 SHALL have parameter TX_TIMEOUT, default 2000: clk cycles allowed from tx_req to tx_done.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports ctl_req / dat_req  input  1 each  level request from tcp_server (control segment) / tcp_vlg_tx_queue (data segment).
REQ-006 SHALL have ports ctl_seq, ctl_ack, dat_seq, dat_ack  input  32 each  segment sequence/ack numbers.
REQ-007 SHALL have ports ctl_flags, dat_flags  input  9 each  TCP flags.
REQ-008 SHALL have ports ctl_len, dat_len  input  16 each  payload length; ctl_len is ignored and driven as 0.
REQ-009 SHALL have ports ctl_cs, dat_cs  input  32 each  payload checksum; ctl_cs is ignored and driven as 0.
REQ-010 SHALL have ports ctl_done, dat_done, ctl_err, dat_err  output  1 each  one-cycle completion/timeout pulse to the granted requester.
REQ-011 SHALL have ports tx_req output 1, tx_seq output 32, tx_ack output 32, tx_flags output 9, tx_len output 16, tx_cs output 32, tx_sel output 1 (0=ctl, 1=dat): header to tcp_vlg_tx.
REQ-012 SHALL have ports tx_busy, tx_done  input  1 each  status from tcp_vlg_tx.

Function
REQ-013 SHALL implement FSM with states IDLE, SEND, WAIT.
REQ-014 IDLE: requests sampled only here. If either req is high, SHALL select a winner, latch its header into tx_* registers and go to SEND.
REQ-015 Priority SHALL be ctl over dat, except when burst_cnt == CTL_BURST and dat_req is high, in which case dat SHALL win.
REQ-016 burst_cnt SHALL increment on each ctl grant made while dat_req is high, saturate at CTL_BURST, and clear on any dat grant or when dat_req is low in IDLE.
REQ-017 SEND: tx_req SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT. Latency is req sampled at cycle N, tx_req high at N+1.
REQ-018 WAIT: on tx_done, the requester's done SHALL pulse on the next cycle and the FSM SHALL return to IDLE.
REQ-019 WAIT: the timer SHALL start at 0 in SEND. If it reaches TX_TIMEOUT-1 without tx_done, the requester's err SHALL pulse, no done SHALL pulse, and the FSM SHALL go to IDLE.
REQ-020 tx_done and timeout expiry in the same cycle SHALL resolve as done.
REQ-021 tx_seq/ack/flags/len/cs/sel SHALL be held stable from SEND until the FSM returns to IDLE; requester inputs changing during WAIT SHALL be ignored.
REQ-022 A requester dropping req during SEND/WAIT SHALL NOT abort the transfer; its done/err SHALL still pulse.
REQ-023 The FSM SHALL spend at least one cycle in IDLE between grants, giving back-to-back tx_req spacing of at least tx-duration + 2.
REQ-024 tx_done received in IDLE or SEND SHALL be ignored; tx_busy is informational only and SHALL NOT gate the FSM.
REQ-025 At most one of ctl_done, dat_done, ctl_err, dat_err SHALL be high in any cycle.

Reset
REQ-026 While rst is high, the FSM SHALL be in IDLE and the following SHALL be 0: burst_cnt, timer, tx_req, tx_sel, all tx_* header registers, and all done/err outputs.
REQ-027 rst asserted mid-WAIT SHALL abort immediately with no done/err pulse; after release, the first grant SHALL follow REQ-014/015.

Verification
REQ-028 ctl_req=1 alone with ctl_seq=0x100, ctl_flags=ACK: tx_req one cycle later, tx_sel=0, tx_len=0. tx_done 10 cycles later: ctl_done pulses once on the following cycle.
REQ-029 ctl_req and dat_req both held high, CTL_BURST=4, tcp_vlg_tx completing each in 5 cycles: grant order ctl,ctl,ctl,ctl,dat,ctl...
REQ-030 dat_req with dat_len=1400, dat_cs=0xABCD1234, tx_done never asserted, TX_TIMEOUT=2000: dat_err pulses 2000 cycles after tx_req, FSM returns to IDLE, dat_done stays 0.
REQ-031 dat inputs changed and dat_req dropped during WAIT: tx_* stay at latched values and dat_done still pulses on tx_done.
REQ-032 rst pulsed 3 cycles into WAIT: all outputs 0, no done/err pulse, and a subsequent ctl_req is granted normally.
REQ-033 tx_done coincident with the timeout cycle: done pulses and err does not.
